boot_loader: RTL

- Byte-stream program loader that fills the CPU instruction memory and data memory before execution, then releases the CPU by asserting start.
- It is the write-side counterpart of the bench dump path: that path reads registers and memories out of the CPU, and this block writes the memories in.
- Sits between an external byte source (host link or bench driver) and the CPU memory write ports plus start_i.

---
 rtl/boot_loader.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Byte-stream program loader: fills instruction and data memory from a
// CMD/ADDR/COUNT/payload packet stream, then releases the CPU with start_o.
module boot_loader #(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [7:0]         byte_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_data_o,
  output logic               dmem_we_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [7:0]         dmem_data_o,
  output logic               start_o,
  output logic               busy_o,
  output logic               error_o,
  output logic [15:0]        load_count_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_COUNT   = 3'd2,
    S_PAYLOAD = 3'd3,
    S_RUN     = 3'd4
  } state_t;

  localparam logic [7:0] CMD_IMEM = 8'h01;
  localparam logic [7:0] CMD_DMEM = 8'h02;
  localparam logic [7:0] CMD_GO   = 8'h03;

  state_t               state_q, state_d;
  logic                 is_imem_q, is_imem_d;
  logic [IMEM_AW-1:0]   iptr_q, iptr_d;
  logic [DMEM_AW-1:0]   dptr_q, dptr_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [23:0]          word_q, word_d;
  logic [1:0]           bidx_q, bidx_d;
  logic                 imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]          imem_data_q, imem_data_d;
  logic                 dmem_we_q, dmem_we_d;
  logic [DMEM_AW-1:0]   dmem_addr_q, dmem_addr_d;
  logic [7:0]           dmem_data_q, dmem_data_d;
  logic                 error_q, error_d;
  logic [15:0]          load_count_q, load_count_d;

  logic accept;
  logic last_byte;

  // A byte transfers whenever the source offers one and we are not running.
  assign accept    = valid_i && (state_q != S_RUN);
  // The final payload byte is the one that completes the last word/byte of COUNT.
  assign last_byte = (cnt_q == 8'd1) && (!is_imem_q || (bidx_q == 2'd3));

  // State and datapath registers; reset clears everything, including any partial word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      is_imem_q    <= 1'b0;
      iptr_q       <= '0;
      dptr_q       <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      bidx_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_data_q  <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_data_q  <= '0;
      error_q      <= 1'b0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      is_imem_q    <= is_imem_d;
      iptr_q       <= iptr_d;
      dptr_q       <= dptr_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      bidx_q       <= bidx_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_data_q  <= imem_data_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_data_q  <= dmem_data_d;
      error_q      <= error_d;
      load_count_q <= load_count_d;
    end
  end

  // Next-state decode of the packet framing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (byte_i == CMD_IMEM || byte_i == CMD_DMEM) state_d = S_ADDR;
          else if (byte_i == CMD_GO)                    state_d = S_RUN;
        end
      end
      S_ADDR:    if (accept) state_d = S_COUNT;
      S_COUNT:   if (accept) state_d = (byte_i == 8'd0) ? S_IDLE : S_PAYLOAD;
      S_PAYLOAD: if (accept && last_byte) state_d = S_IDLE;
      S_RUN:     state_d = S_RUN;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath: latch command/pointer/count, assemble words, issue one-cycle write strobes.
  always_comb begin
    is_imem_d    = is_imem_q;
    iptr_d       = iptr_q;
    dptr_d       = dptr_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    bidx_d       = bidx_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_data_d  = imem_data_q;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_data_d  = dmem_data_q;
    error_d      = error_q;
    load_count_d = load_count_q;
    if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          if (byte_i == CMD_IMEM)      is_imem_d = 1'b1;
          else if (byte_i == CMD_DMEM) is_imem_d = 1'b0;
          else if (byte_i != CMD_GO)   error_d   = 1'b1;
        end
        S_ADDR: begin
          // Each memory takes only as many address bits as it has.
          iptr_d = IMEM_AW'(byte_i);
          dptr_d = DMEM_AW'(byte_i);
          bidx_d = 2'd0;
        end
        S_COUNT: cnt_d = byte_i;
        S_PAYLOAD: begin
          if (is_imem_q) begin
            if (bidx_q == 2'd3) begin
              imem_we_d   = 1'b1;
              imem_addr_d = iptr_q;
              imem_data_d = {byte_i, word_q};
              iptr_d      = iptr_q + IMEM_AW'(1);
              cnt_d       = cnt_q - 8'd1;
              bidx_d      = 2'd0;
            end else begin
              // Little-endian: earlier bytes slide toward bit 0.
              word_d = {byte_i, word_q[23:8]};
              bidx_d = bidx_q + 2'd1;
            end
          end else begin
            dmem_we_d   = 1'b1;
            dmem_addr_d = dptr_q;
            dmem_data_d = byte_i;
            dptr_d      = dptr_q + DMEM_AW'(1);
            cnt_d       = cnt_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
    if ((imem_we_d || dmem_we_d) && (load_count_q != 16'hFFFF))
      load_count_d = load_count_q + 16'd1;
  end

  // Outputs decoded from state; combinational so reset is visible without a clock edge.
  always_comb begin
    ready_o      = (state_q != S_RUN);
    start_o      = (state_q == S_RUN);
    busy_o       = (state_q == S_ADDR) || (state_q == S_COUNT) || (state_q == S_PAYLOAD);
    imem_we_o    = imem_we_q;
    imem_addr_o  = imem_addr_q;
    imem_data_o  = imem_data_q;
    dmem_we_o    = dmem_we_q;
    dmem_addr_o  = dmem_addr_q;
    dmem_data_o  = dmem_data_q;
    error_o      = error_q;
    load_count_o = load_count_q;
  end

endmodule
